// File: rtl/triangle_wave_generator_if.sv
// Generic AXI-stream style channel: valid/ready handshake plus a data bus.
//   valid  - source asserts when data carries a word
//   ready  - sink asserts when it can take the word
//   data   - payload, DWIDTH bits
// Modports: master drives valid/data and observes ready; slave the reverse.
interface triangle_wave_generator_if #(
  parameter int DWIDTH = 32
) ();
  logic              valid;
  logic              ready;
  logic [DWIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/triangle_wave_generator.sv
// Phase-accumulator triangle waveform source, PARALLEL_SAMPLES signed samples
// per clock, lane 0 (earliest sample) in the LSBs.
// Ports:
//   clk        - clock
//   reset      - asynchronous, active-high reset
//   data_out   - stream master, PARALLEL_SAMPLES*SAMPLE_WIDTH bits per word
//   config_in  - stream slave, {enable, step[PHASE_BITS-1:0]}; always ready,
//                every valid cycle is a write that restarts the phase at 0
// Output backpressure stalls both pipeline stages together, so words are
// never lost or repeated.
module triangle_wave_generator #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int PARALLEL_SAMPLES = 16,
  parameter int PHASE_BITS       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  triangle_wave_generator_if.master   data_out,
  triangle_wave_generator_if.slave    config_in
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int P  = PARALLEL_SAMPLES;
  localparam int PB = PHASE_BITS;
  localparam int DW = P * W;

  // Fold the phase into a rising/falling ramp, keep the top W bits of the
  // ramp and flip its MSB to turn offset binary into two's complement.
  function automatic logic signed [W-1:0] tri_sample(input logic [PB-1:0] p);
    logic [PB-2:0] t;
    logic [W-1:0]  u;
    t = p[PB-1] ? ~p[PB-2:0] : p[PB-2:0];
    u = t[PB-2 -: W];
    return {~u[W-1], u[W-2:0]};
  endfunction

  logic          enable;
  logic [PB-1:0] step;
  logic [PB-1:0] phase_base;
  logic [PB-1:0] lane_off [P];
  logic [PB-1:0] base_inc;

  logic          vld_p1;
  logic [PB-1:0] phase_p1 [P];

  logic          vld_p2;
  logic [DW-1:0] data_p2;

  logic          advance;
  logic          cfg_wr;

  assign config_in.ready = 1'b1;
  assign cfg_wr          = config_in.valid;
  assign advance         = data_out.ready || !vld_p2;

  assign data_out.valid  = vld_p2;
  assign data_out.data   = data_p2;

  always_comb begin
    for (int i = 0; i < P; i++) begin
      lane_off[i] = step * PB'(i);
    end
    base_inc = step * PB'(P);
  end

  // Configuration and phase accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable     <= 1'b0;
      step       <= '0;
      phase_base <= '0;
    end else if (cfg_wr) begin
      enable     <= config_in.data[PB];
      step       <= config_in.data[PB-1:0];
      phase_base <= '0;
    end else if (advance && enable) begin
      phase_base <= phase_base + base_inc;
    end
  end

  // Stage 1: lane phases. A config write squashes the slot so no word mixes
  // old and new settings.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < P; i++) begin
        phase_p1[i] <= '0;
      end
    end else if (cfg_wr) begin
      vld_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= enable;
      if (enable) begin
        for (int i = 0; i < P; i++) begin
          phase_p1[i] <= phase_base + lane_off[i];
        end
      end
    end
  end

  // Stage 2: triangle mapping into the output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (advance) begin
      vld_p2 <= vld_p1;
      for (int i = 0; i < P; i++) begin
        data_p2[i*W +: W] <= tri_sample(phase_p1[i]);
      end
    end
  end

endmodule

// File: tb/tb_triangle_wave_generator.sv
module tb_triangle_wave_generator;

  localparam int P  = 16;
  localparam int W  = 16;
  localparam int PB = 32;
  localparam int DW = P * W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  triangle_wave_generator_if #(.DWIDTH(DW))   dout ();
  triangle_wave_generator_if #(.DWIDTH(PB+1)) cfg ();

  triangle_wave_generator #(
    .SAMPLE_WIDTH     (W),
    .PARALLEL_SAMPLES (P),
    .PHASE_BITS       (PB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_out  (dout),
    .config_in (cfg)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic en, input logic [PB-1:0] st);
    cfg.valid = 1'b1;
    cfg.data  = {en, st};
    tick();
    cfg.valid = 1'b0;
    cfg.data  = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Waits (bounded) for a transfer with ready held high, returns the word.
  task automatic take_word(output logic [DW-1:0] w);
    int n;
    n = 0;
    dout.ready = 1'b1;
    while (!dout.valid && n < 20) begin
      tick();
      n++;
    end
    if (!dout.valid) chk("word_wait", DW'(dout.valid), DW'(1));
    w = dout.data;
    tick();
  endtask

  // Expected words for step = 2^26: four-word period, 0x800 per lane.
  function automatic logic [DW-1:0] exp26(input int k);
    logic [DW-1:0] w;
    for (int i = 0; i < P; i++) begin
      case (k % 4)
        0:       w[i*W +: W] = 16'(32'h8000 + i * 32'h0800);
        1:       w[i*W +: W] = 16'(i * 32'h0800);
        2:       w[i*W +: W] = 16'(32'h7FFF - i * 32'h0800);
        default: w[i*W +: W] = 16'(32'hFFFF - i * 32'h0800);
      endcase
    end
    return w;
  endfunction

  // First word for step = 2^27: 0x1000 per lane, wrapping past lane 7.
  function automatic logic [DW-1:0] exp27_first();
    logic [DW-1:0] w;
    for (int i = 0; i < P; i++) begin
      w[i*W +: W] = 16'(32'h8000 + i * 32'h1000);
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] all_lanes(input logic [W-1:0] v);
    logic [DW-1:0] w;
    for (int i = 0; i < P; i++) w[i*W +: W] = v;
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] held;
    logic          hold;
    logic          seen;
    int            k;
    int            got_n;
    int            cyc;
    int            old_n;

    reset      = 1'b1;
    dout.ready = 1'b1;
    cfg.valid  = 1'b0;
    cfg.data   = '0;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset: no output without a config write
    chk("rst_cfg_ready", DW'(cfg.ready), DW'(1));
    chk("rst_data", dout.data, '0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dout.valid) seen = 1'b1;
      tick();
    end
    chk("idle_no_valid", DW'(seen), DW'(0));

    // step = 2^26, always ready: 8 words, two full periods
    cfg_write(1'b1, 32'h0400_0000);
    for (int j = 0; j < 8; j++) begin
      take_word(w);
      chk($sformatf("s26_word%0d", j), w, exp26(j));
    end

    // Same step under random backpressure
    pulse_reset();
    dout.ready = 1'b0;
    cfg_write(1'b1, 32'h0400_0000);
    got_n = 0;
    cyc   = 0;
    while (got_n < 12 && cyc < 500) begin
      dout.ready = 1'($urandom_range(0, 1));
      hold = 1'b0;
      held = '0;
      if (dout.valid && dout.ready) begin
        chk($sformatf("bp_word%0d", got_n), dout.data, exp26(got_n));
        got_n++;
      end else if (dout.valid) begin
        hold = 1'b1;
        held = dout.data;
      end
      tick();
      if (hold) begin
        chk("bp_hold_valid", DW'(dout.valid), DW'(1));
        chk("bp_hold_data", dout.data, held);
      end
      cyc++;
    end
    chk("bp_word_count", DW'(got_n), DW'(12));

    // Mid-stream step change: old words drain, new words restart at phase 0
    pulse_reset();
    dout.ready = 1'b1;
    cfg_write(1'b1, 32'h0400_0000);
    take_word(w);
    chk("mid_w0", w, exp26(0));
    take_word(w);
    chk("mid_w1", w, exp26(1));
    k = 2;
    if (dout.valid) begin
      chk("mid_inflight", dout.data, exp26(k));
      k++;
    end
    cfg_write(1'b1, 32'h0800_0000);
    seen  = 1'b0;
    old_n = 0;
    for (int j = 0; j < 4 && !seen; j++) begin
      take_word(w);
      if (w == exp27_first()) begin
        seen = 1'b1;
      end else begin
        chk("mid_old_drain", w, exp26(k));
        k++;
        old_n++;
      end
    end
    chk("mid_new_found", DW'(seen), DW'(1));
    chk("mid_old_count_le2", DW'(old_n <= 2), DW'(1));
    take_word(w);
    chk("mid_new_w1_lanes01", DW'(w[2*W-1:0]), DW'(32'h6FFF_7FFF));

    // Disable: at most one more word, then valid low from cycle 2
    dout.ready = 1'b1;
    cfg_write(1'b0, 32'h0800_0000);
    tick();
    chk("dis_valid_low", DW'(dout.valid), DW'(0));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dout.valid) seen = 1'b1;
      tick();
    end
    chk("dis_stays_low", DW'(seen), DW'(0));

    // Asynchronous reset while stalled with a pending word
    pulse_reset();
    dout.ready = 1'b0;
    cfg_write(1'b1, 32'h0400_0000);
    for (int i = 0; i < 5 && !dout.valid; i++) tick();
    chk("arst_pending", DW'(dout.valid), DW'(1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_valid", DW'(dout.valid), DW'(0));
    chk("arst_data", dout.data, '0);
    @(negedge clk);
    reset      = 1'b0;
    dout.ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dout.valid) seen = 1'b1;
    end
    chk("arst_no_output", DW'(seen), DW'(0));

    // step = 0: constant minimum on every lane
    cfg_write(1'b1, 32'h0000_0000);
    for (int j = 0; j < 3; j++) begin
      take_word(w);
      chk($sformatf("s0_word%0d", j), w, all_lanes(16'h8000));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/triangle_wave_generator.md
# triangle_wave_generator

Single-channel, phase-accumulator-based triangle waveform source for the transmit chain. It emits PARALLEL_SAMPLES signed samples per clock on an AXI-stream output. One instance per channel feeds the per-channel data input of the multichannel DAC prescaler. Frequency and enable are programmed through a small AXI-stream config port, and output backpressure stalls the whole pipeline without dropping or duplicating words.

## Interface
- SAMPLE_WIDTH, 16: output sample width, signed two's complement; must be ≤ PHASE_BITS-1
- PARALLEL_SAMPLES, 16: samples per output word; lane 0 is the earliest sample, in the LSBs
- PHASE_BITS, 32: phase accumulator and step width
- clk  input  1: clock
- reset  input  1: asynchronous, active-high reset
- data_out  Axis_If.Master_Stream  DWIDTH=PARALLEL_SAMPLES*SAMPLE_WIDTH: sample words; lane i occupies bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- config_in  Axis_If.Slave  DWIDTH=PHASE_BITS+1: {enable, step[PHASE_BITS-1:0]}

## Operation
- config_in.ready is tied to 1; every config_in.valid cycle is a write.
- State registers and reset values: enable=0, step=0, phase_base=0, s1_valid=0, s1_phase[0..P-1]=0, data_out.valid=0, data_out.data=0.
- Config write updates:
  - enable ← data[PHASE_BITS]
  - step ← data[PHASE_BITS-1:0]
  - phase_base ← 0; a write always restarts the phase at 0.
- advance = data_out.ready || !data_out.valid. The pipeline moves only when advance=1.
- Stage 1, on advance with no config write in that cycle:
  - If enable=1: s1_phase[i] ← phase_base + i*step (mod 2^PHASE_BITS); phase_base ← phase_base + PARALLEL_SAMPLES*step (mod 2^PHASE_BITS); s1_valid ← 1.
  - If enable=0: s1_valid ← 0; phase_base holds.
- Stage 1 during a config write cycle: s1_valid ← 0 regardless of advance. Stage 1 does not load during that cycle.
- Stage 2 (output), on advance: data_out.valid ← s1_valid; lane i ← tri(s1_phase[i]).
- Triangle map, for phase p:
  - t = p[PHASE_BITS-1] ? ~p[PHASE_BITS-2:0] : p[PHASE_BITS-2:0]
  - u = t[PHASE_BITS-2 -: SAMPLE_WIDTH]
  - sample = {~u[MSB], u[MSB-1:0]}
  - p=0 gives the minimum (-2^(W-1)); p=2^(PHASE_BITS-1) gives the maximum (2^(W-1)-1).
- AXI-stream rules:
  - Once data_out.valid=1, data and valid hold until a cycle with data_out.ready=1.
  - Disabling never withdraws a pending output word. Words already in stage 1/2 drain normally, except the stage 1 word squashed by a config write.
- Step change mid-stream: words computed before the write are emitted with the old step. New-step words start at phase 0.
- Wrap-around of phase_base and lane phases is modular with no saturation. Any step value, including 0 and ≥2^(PHASE_BITS-1), is legal.

## Timing
- Config write accepted in cycle 0 with enable=1 and data_out.ready=1:
  - stage 1 loads at the cycle-1 edge
  - data_out.valid=1 from cycle 2, carrying lanes for phase 0..(P-1)*step
- Throughput: one word per cycle while ready=1.
- Stall: ready low for N cycles holds both stages; no word is lost or repeated.
- Enable=0 write in cycle 0 with ready=1: at most one further valid word (stage 2 contents), then valid=0 from cycle 2 onward.
- Reset assertion at any time: all outputs go to reset values immediately (asynchronous). The first valid word then requires a new config write.

## Test plan
- Reset, no config write -> data_out.valid stays 0 for 100 cycles; config_in.ready=1.
- Write {1, step=0}, ready=1 -> from cycle 2, every lane = 0x8000 on every word.
- Write {1, step=2^26}, P=16, W=16 -> words in this order, repeating with period 4 words:
  - Word 0: lane0=0x8000, lane1=0x8800, …, lane15=0xF800
  - Word 1: lane0=0x0000 … lane15=0x7800
  - Word 2: lane0=0x7FFF, lane1=0x77FF, …
  - Word 3: lane0=0xFFFF, … (descending)
- Same step as above, with ready toggled by a random 50% pattern -> accepted-word sequence identical to the always-ready run, and data stable while valid && !ready.
- Mid-stream write {1, 2^27} -> remaining old-step words drain, then the next word restarts at lane0=0x8000, lane1=0x9000; write {0, x} -> valid drops within 2 cycles of ready=1.
- Assert reset while streaming with ready=0 -> valid=0 and data=0 immediately; no output after release until a new config write.
